// File: rtl/rti_scheduler.sv
// JTAG USER-chain Run-Test/Idle cycle scheduler: a host-programmed counter of
// TCK cycles spent in Run-Test/Idle that strobes fire once or periodically.
module rti_scheduler #(
  parameter int DR_WIDTH    = 32,
  parameter int COUNT_WIDTH = 24
) (
  input  logic tck,
  input  logic test_logic_reset,
  input  logic tdi,
  output logic tdo,
  input  logic run_test_idle,
  input  logic ir_is_user,
  input  logic capture_dr,
  input  logic shift_dr,
  input  logic update_dr,
  output logic fire,
  output logic armed,
  output logic done
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ONCE   = 2'b01;
  localparam logic [1:0] ST_REPEAT = 2'b10;
  localparam logic [1:0] ST_DONE   = 2'b11;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_ONCE   = 2'b01;
  localparam logic [1:0] OP_REPEAT = 2'b10;
  localparam logic [1:0] OP_DISARM = 2'b11;

  localparam logic [5:0] TOTAL_MAX = 6'd63;

  logic [DR_WIDTH-1:0]    sr_q, sr_d;
  logic [1:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] target_q, target_d;
  logic [COUNT_WIDTH-1:0] elapsed_q, elapsed_d;
  logic [5:0]             fire_total_q, fire_total_d;
  logic                   fire_q, fire_d;

  logic [DR_WIDTH-1:0]    status_w;
  logic [1:0]             opcode_w;
  logic [COUNT_WIDTH-1:0] operand_w;
  logic [COUNT_WIDTH-1:0] elapsed_inc_w;
  logic                   cmd_valid_w;
  logic                   counting_w;

  assign armed = (state_q == ST_ONCE) || (state_q == ST_REPEAT);
  assign done  = (state_q == ST_DONE);
  assign fire  = fire_q;
  assign tdo   = sr_q[0];

  assign opcode_w      = sr_q[31:30];
  assign operand_w     = sr_q[COUNT_WIDTH-1:0];
  assign elapsed_inc_w = elapsed_q + COUNT_WIDTH'(1);
  assign cmd_valid_w   = ir_is_user && update_dr;
  assign counting_w    = armed && run_test_idle;

  always_comb begin
    status_w                   = '0;
    status_w[COUNT_WIDTH-1:0]  = elapsed_q;
    status_w[29:24]            = fire_total_q;
    status_w[31:30]            = state_q;
  end

  // NOTE: every next-state signal takes its default first, so no path leaves one unassigned (no latches).
  always_comb begin
    sr_d         = sr_q;
    state_d      = state_q;
    target_d     = target_q;
    elapsed_d    = elapsed_q;
    fire_total_d = fire_total_q;
    fire_d       = 1'b0;

    if (ir_is_user && capture_dr) begin
      sr_d = status_w;
    end else if (ir_is_user && shift_dr) begin
      sr_d = {tdi, sr_q[DR_WIDTH-1:1]};
    end

    // An update command takes priority; a coinciding count step is dropped.
    if (cmd_valid_w) begin
      case (opcode_w)
        OP_ONCE, OP_REPEAT: begin
          target_d  = (operand_w == '0) ? COUNT_WIDTH'(1) : operand_w;
          elapsed_d = '0;
          state_d   = (opcode_w == OP_ONCE) ? ST_ONCE : ST_REPEAT;
        end
        OP_DISARM: begin
          state_d      = ST_IDLE;
          elapsed_d    = '0;
          fire_total_d = '0;
        end
        OP_NOP:  ;
        default: ;
      endcase
    end else if (counting_w) begin
      if (elapsed_inc_w == target_q) begin
        fire_d       = 1'b1;
        fire_total_d = (fire_total_q == TOTAL_MAX) ? TOTAL_MAX : fire_total_q + 6'd1;
        if (state_q == ST_ONCE) begin
          state_d   = ST_DONE;
          elapsed_d = elapsed_inc_w;
        end else begin
          elapsed_d = '0;
        end
      end else begin
        elapsed_d = elapsed_inc_w;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge tck or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      sr_q         <= '0;
      state_q      <= ST_IDLE;
      target_q     <= '0;
      elapsed_q    <= '0;
      fire_total_q <= '0;
      fire_q       <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      state_q      <= state_d;
      target_q     <= target_d;
      elapsed_q    <= elapsed_d;
      fire_total_q <= fire_total_d;
      fire_q       <= fire_d;
    end
  end

endmodule

// File: tb/tb_rti_scheduler.sv
// Directed bench for rti_scheduler: a cycle-level behavioural model checked
// every falling edge, plus hand-computed status words and fire counts.
module tb_rti_scheduler;

  logic tck = 1'b0;
  logic rst;
  logic tdi = 1'b0;
  logic run_test_idle = 1'b0;
  logic ir_is_user = 1'b0;
  logic capture_dr = 1'b0;
  logic shift_dr = 1'b0;
  logic update_dr = 1'b0;
  logic tdo, fire, armed, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: 0 idle, 1 armed once, 2 armed repeat, 3 done.
  typedef struct {
    int state;
    int target;
    int elapsed;
    int total;
    bit fire;
  } model_t;

  model_t      m;
  logic [31:0] m_cmd = '0;
  int          edges = 0;
  int          fire_seen = 0;
  int          last_fire_edge = -1;

  rti_scheduler #(.DR_WIDTH(32), .COUNT_WIDTH(24)) dut (
    .tck              (tck),
    .test_logic_reset (rst),
    .tdi              (tdi),
    .tdo              (tdo),
    .run_test_idle    (run_test_idle),
    .ir_is_user       (ir_is_user),
    .capture_dr       (capture_dr),
    .shift_dr         (shift_dr),
    .update_dr        (update_dr),
    .fire             (fire),
    .armed            (armed),
    .done             (done)
  );

  always #5 tck = ~tck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic model_t model_reset();
    model_t r;
    r.state = 0; r.target = 0; r.elapsed = 0; r.total = 0; r.fire = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(model_t cur, logic upd, logic rti, logic [31:0] cmd);
    model_t n = cur;
    n.fire = 1'b0;
    if (upd) begin
      case (cmd[31:30])
        2'b01, 2'b10: begin
          n.target  = (cmd[23:0] == 24'd0) ? 1 : int'(cmd[23:0]);
          n.elapsed = 0;
          n.state   = int'(cmd[31:30]);
        end
        2'b11: begin
          n.state = 0; n.elapsed = 0; n.total = 0;
        end
        default: ;
      endcase
    end else if (rti && (cur.state == 1 || cur.state == 2)) begin
      n.elapsed = cur.elapsed + 1;
      if (n.elapsed == cur.target) begin
        n.fire  = 1'b1;
        n.total = (cur.total >= 63) ? 63 : cur.total + 1;
        if (cur.state == 1) n.state = 3;
        else n.elapsed = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] model_status(model_t cur);
    logic [1:0]  st = cur.state[1:0];
    logic [5:0]  tot = cur.total[5:0];
    logic [23:0] el = cur.elapsed[23:0];
    return {st, tot, el};
  endfunction

  always @(posedge tck or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, ir_is_user && update_dr, run_test_idle, m_cmd);
  end

  always @(posedge tck) edges <= edges + 1;

  always @(negedge tck) begin
    check("fire_vs_model", {31'd0, fire}, {31'd0, m.fire});
    check("armed_vs_model", {31'd0, armed}, {31'd0, (m.state == 1 || m.state == 2)});
    check("done_vs_model", {31'd0, done}, {31'd0, (m.state == 3)});
    if (fire === 1'b1) begin
      fire_seen++;
      last_fire_edge = edges;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge tck);
      #1;
    end
  endtask

  task automatic shift_word(input logic [31:0] w, output logic [31:0] rd);
    ir_is_user = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd[i]    = tdo;
      shift_dr = 1'b1;
      tdi      = w[i];
      tick();
    end
    shift_dr = 1'b0;
    tdi      = 1'b0;
  endtask

  task automatic read_status(input string name, input logic [31:0] lit);
    logic [31:0] rd;
    logic [31:0] exp;
    exp = model_status(m);
    shift_word(32'd0, rd);
    check({name, "_model"}, rd, exp);
    check({name, "_literal"}, rd, lit);
  endtask

  task automatic send_cmd(input logic [31:0] cmd, input logic upd_ir);
    logic [31:0] rd;
    shift_word(cmd, rd);
    m_cmd      = cmd;
    ir_is_user = upd_ir;
    update_dr  = 1'b1;
    tick();
    update_dr  = 1'b0;
    ir_is_user = 1'b1;
  endtask

  task automatic rti(input int n);
    run_test_idle = 1'b1;
    tick(n);
    run_test_idle = 1'b0;
  endtask

  initial begin
    int c0;
    int f0;
    m   = model_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check("reset_armed", {31'd0, armed}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_fire", {31'd0, fire}, 32'd0);
    read_status("reset_status", 32'h0000_0000);

    // Single shot, target 5.
    send_cmd(32'h4000_0005, 1'b1);
    check("once_armed", {31'd0, armed}, 32'd1);
    c0 = edges;
    f0 = fire_seen;
    rti(8);
    tick();
    check("once_fire_count", fire_seen - f0, 32'd1);
    check("once_fire_edge", last_fire_edge, c0 + 5);
    check("once_done", {31'd0, done}, 32'd1);
    check("once_disarmed", {31'd0, armed}, 32'd0);
    read_status("once_status", 32'hC100_0005);

    // Disarm clears fire_total, then periodic with target 3.
    send_cmd(32'hC000_0000, 1'b1);
    check("disarm_idle", {30'd0, done, armed}, 32'd0);
    send_cmd(32'h8000_0003, 1'b1);
    c0 = edges;
    f0 = fire_seen;
    rti(10);
    tick();
    check("repeat_fire_count", fire_seen - f0, 32'd3);
    check("repeat_last_edge", last_fire_edge, c0 + 9);
    read_status("repeat_status", 32'h8300_0001);

    // Pausing outside Run-Test/Idle retains the count.
    send_cmd(32'h4000_0004, 1'b1);
    f0 = fire_seen;
    rti(2);
    tick(5);
    check("pause_no_fire", fire_seen - f0, 32'd0);
    check("pause_still_armed", {31'd0, armed}, 32'd1);
    rti(2);
    tick();
    check("pause_fire_count", fire_seen - f0, 32'd1);
    read_status("pause_status", 32'hC400_0004);

    // Target 0 behaves as 1: fire every RTI cycle, total saturates.
    send_cmd(32'h8000_0000, 1'b1);
    f0 = fire_seen;
    rti(70);
    tick();
    check("zero_fire_count", fire_seen - f0, 32'd70);
    read_status("zero_status", 32'hBF00_0000);

    // Reset mid-count aborts without a fire.
    send_cmd(32'h4000_000A, 1'b1);
    rti(6);
    check("midreset_armed_before", {31'd0, armed}, 32'd1);
    @(posedge tck);
    #3;
    rst = 1'b1;
    #1;
    check("midreset_armed", {31'd0, armed}, 32'd0);
    check("midreset_fire", {31'd0, fire}, 32'd0);
    tick(2);
    rst = 1'b0;
    f0 = fire_seen;
    rti(10);
    tick();
    check("midreset_no_fire", fire_seen - f0, 32'd0);
    read_status("midreset_status", 32'h0000_0000);

    // Update with ir_is_user low is ignored.
    send_cmd(32'h4000_0003, 1'b0);
    check("noir_armed", {31'd0, armed}, 32'd0);
    f0 = fire_seen;
    rti(5);
    tick();
    check("noir_no_fire", fire_seen - f0, 32'd0);
    read_status("noir_status", 32'h0000_0000);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
